pixel_readout_buffer: RTL and testbench
=======================================

// Module: pixel_readout_buffer
// PURPOSE
//   Downstream of the exposure controller. Uses its NRE_1/NRE_2/ADC/Erase strobes to capture digitised
//   pixel rows into a capture bank. Moves each complete frame to a drain bank (double-buffered).
//   Streams pixels out one word at a time over a valid/ready interface.
// PARAMETERS
//   NCOLS   2  pixels per row (columns digitised in parallel)
//   DATA_W  8  bits per pixel sample
// PORTS
//   Clk        in   1              system clock; all logic on rising edge
//   Reset      in   1              synchronous, active-high reset
//   NRE_1      in   1              active-low read enable, row 0
//   NRE_2      in   1              active-low read enable, row 1
//   ADC        in   1              conversion strobe; sample taken on its rising edge
//   Erase      in   1              start-of-frame; clears partial capture
//   Pix_data   in   NCOLS*DATA_W   ADC result for selected row, col0 in LSBs
//   Out_ready  in   1              consumer accepts Out_data this cycle
//   Out_data   out  DATA_W         pixel word
//   Out_valid  out  1              Out_data valid
//   Out_last   out  1              final word of frame
//   Overrun    out  1              sticky: complete frame dropped
//   Seq_err    out  1              sticky: ADC edge with illegal NRE combination
// BEHAVIOUR
//   - Reset: all outputs 0; both banks invalid; row mask 0; word index 0; FSM in IDLE.
//     Reset mid-drain discards the frame; Out_valid is 0 from the next edge.
//   - ADC edge: registered copy adc_q. Edge = ADC & ~adc_q, evaluated in cycle k; data written at edge k.
//   - Edge with NRE_1=0, NRE_2=1 stores Pix_data into row 0 and sets mask[0].
//     Edge with NRE_1=1, NRE_2=0 does the same for row 1 and mask[1].
//   - Edge with both NRE low or both high: no write; Seq_err<=1. Seq_err clears only on Reset.
//   - Re-capturing an already captured row overwrites it; mask unchanged.
//   - Erase=1 clears the mask and has priority over a same-cycle ADC edge (that edge is ignored).
//     Erase never affects the drain bank.
//   - Completion: in the cycle mask==2'b11, hand-off occurs at the next edge.
//     If drain bank is free: copy capture bank to drain, clear mask, FSM goes to DRAIN.
//     If drain is busy: frame dropped, mask cleared, Overrun<=1 (sticky until Reset).
//   - FSM states:
//     IDLE -> DRAIN on hand-off.
//     DRAIN -> IDLE on the accepted last word.
//     If a queued hand-off is pending, DRAIN -> DRAIN with the index reset to 0, no bubble.
//   - DRAIN: Out_valid=1; Out_data=pixel[idx].
//     Order: r0c0..r0c(NCOLS-1), r1c0..r1c(NCOLS-1).
//     idx increments on Out_valid&Out_ready; Out_data/Out_valid held stable while Out_ready=0.
//   - Out_last=1 on word 2*NCOLS-1 (or on the checksum word, see below).
//   - Latency: the completing row's ADC edge is sampled in cycle k; Out_valid=1 from edge k+2.
//   - Capture of the next frame proceeds during DRAIN.
//     A frame completing on the cycle the last word is accepted counts as drain free: no Overrun.
// CONFIGURATION
//   READOUT_CHECKSUM_EN defined:
//     - One extra word follows the pixels: (sum of all 2*NCOLS pixels) mod 2^DATA_W.
//     - Out_last moves to that word; frame length is 2*NCOLS+1.
//   READOUT_CHECKSUM_EN undefined:
//     - No checksum logic; frame length is 2*NCOLS.
// STRUCTURE
//   - Shared camera package/include: FSM state encoding (IDLE, DRAIN), the row-index constants, and
//     the frame-length constant computed from NCOLS and READOUT_CHECKSUM_EN.
//   - One sub-module, readout_frame_bank: a 2-row x NCOLS x DATA_W register bank with a row write
//     port and a word read mux. Instantiated twice (capture, drain).
//   - Top level holds: ADC edge detect, mask, FSM, index counter, flags, checksum.
// TESTING
//   1. NCOLS=2, ready=1.
//      Row0={0x22,0x11} via NRE_1 + ADC edge, then row1={0x44,0x33} via NRE_2.
//      -> Out_data 0x11,0x22,0x33,0x44 on consecutive cycles; Out_last only with 0x44.
//   2. Same frame with Out_ready toggling 1,0,0,1...
//      -> each word held stable while stalled; exactly 4 handshakes; no duplicate or skipped word.
//   3. Out_ready=0 while two further complete frames are captured.
//      -> 2nd frame queued; 3rd frame dropped, Overrun=1. Releasing ready yields frame1 then frame2.
//   4. Row0 captured, Erase pulse, then row1 captured.
//      -> no output. A later row0+row1 produces a frame with the new data.
//   5. ADC edge with NRE_1=NRE_2=0 -> Seq_err=1, no capture. Reset pulse -> Seq_err=0, all outputs 0.
//   6. With READOUT_CHECKSUM_EN, pixels 0x80,0x40,0x20,0x0A
//      -> 5th word 0xEA with Out_last=1.
//      Reset asserted mid-drain -> Out_valid=0 next cycle.

Source files
------------

// File: rtl/pixel_readout_buffer_pkg.sv
// Shared definitions for the pixel readout path: drain FSM encoding, row indices and frame length.
// The frame length grows by one checksum word when READOUT_CHECKSUM_EN is defined.
package pixel_readout_buffer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic ROW0 = 1'b0;
    localparam logic ROW1 = 1'b1;

    function automatic int frame_len(input int ncols);
`ifdef READOUT_CHECKSUM_EN
        return 2 * ncols + 1;
`else
        return 2 * ncols;
`endif
    endfunction

endpackage

// File: rtl/pixel_readout_buffer_bank.sv
// Two-row frame store: row write port, whole-frame load port, word read mux (r0c0 first).
// Load has priority over a same-cycle row write; reads are combinational.
module readout_frame_bank
    import pixel_readout_buffer_pkg::*;
#(
    parameter int NCOLS  = 2,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic                        wr_row,
    input  logic [NCOLS*DATA_W-1:0]     wr_data,
    input  logic                        load_en,
    input  logic [2*NCOLS*DATA_W-1:0]   load_data,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [DATA_W-1:0]           rd_data,
    output logic [2*NCOLS*DATA_W-1:0]   frame
);

    localparam int ROW_W = NCOLS * DATA_W;

    logic [2*ROW_W-1:0] frame_q;

    always_ff @(posedge clk) begin
        if (load_en) begin
            frame_q <= load_data;
        end else if (wr_en) begin
            if (wr_row == ROW1) begin
                frame_q[2*ROW_W-1:ROW_W] <= wr_data;
            end else begin
                frame_q[ROW_W-1:0] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int w = 0; w < 2 * NCOLS; w++) begin
            if (rd_idx == IDX_W'(w)) begin
                rd_data = frame_q[w*DATA_W +: DATA_W];
            end
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/pixel_readout_buffer.sv
// Captures strobed pixel rows, hands complete frames to a drain bank and streams them valid/ready.
// Out_valid follows the frame-completing ADC edge by two clocks; words hold while Out_ready=0. Option: READOUT_CHECKSUM_EN.
module pixel_readout_buffer
    import pixel_readout_buffer_pkg::*;
#(
    parameter int NCOLS  = 2,
    parameter int DATA_W = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    NRE_1,
    input  logic                    NRE_2,
    input  logic                    ADC,
    input  logic                    Erase,
    input  logic [NCOLS*DATA_W-1:0] Pix_data,
    input  logic                    Out_ready,
    output logic [DATA_W-1:0]       Out_data,
    output logic                    Out_valid,
    output logic                    Out_last,
    output logic                    Overrun,
    output logic                    Seq_err
);

    localparam int FRAME_LEN = frame_len(NCOLS);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t                     state, state_nxt;
    logic                       adc_q, adc_edge, row_ok, row_sel;
    logic [1:0]                 mask;
    logic                       queued;
    logic [IDX_W-1:0]           idx;
    logic                       complete, accept, last_acc, drain_free;
    logic                       load_drain, queue_frame, drop_frame, mask_set, mask_clr, cap_we;
    logic [2*NCOLS*DATA_W-1:0]  cap_frame, drain_frame;
    logic [DATA_W-1:0]          cap_word, pix_word;

    assign adc_edge    = ADC & ~adc_q;
    assign row_ok      = NRE_1 ^ NRE_2;
    assign row_sel     = NRE_1 ? ROW1 : ROW0;
    assign complete    = (mask == 2'b11);
    assign accept      = Out_valid & Out_ready;
    assign last_acc    = accept & (idx == LAST_IDX);
    assign drain_free  = (state == ST_IDLE) | last_acc;

    // A frame that completes while the drain is busy parks in the capture bank; one more is dropped.
    assign load_drain  = (complete & ~queued & drain_free) | (queued & last_acc);
    assign queue_frame = complete & ~queued & ~drain_free;
    assign drop_frame  = complete & queued;
    assign mask_clr    = Erase | complete | (queued & last_acc);
    assign mask_set    = adc_edge & ~Erase & row_ok & ~(queued & last_acc);
    assign cap_we      = mask_set & ~queued & ~queue_frame;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            adc_q   <= 1'b0;
            mask    <= 2'b00;
            queued  <= 1'b0;
            Overrun <= 1'b0;
            Seq_err <= 1'b0;
        end else begin
            adc_q <= ADC;
            mask  <= (mask_clr ? 2'b00 : mask)
                   | (mask_set ? ((row_sel == ROW1) ? 2'b10 : 2'b01) : 2'b00);
            if (queue_frame) begin
                queued <= 1'b1;
            end else if (queued & last_acc) begin
                queued <= 1'b0;
            end
            if (drop_frame) begin
                Overrun <= 1'b1;
            end
            if (adc_edge & ~Erase & ~row_ok) begin
                Seq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (load_drain || last_acc) begin
                idx <= '0;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (load_drain) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_acc)   state_nxt = load_drain ? ST_DRAIN : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    readout_frame_bank #(.NCOLS(NCOLS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_capture (
        .clk       (Clk),
        .wr_en     (cap_we),
        .wr_row    (row_sel),
        .wr_data   (Pix_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    ('0),
        .rd_data   (cap_word),
        .frame     (cap_frame)
    );

    readout_frame_bank #(.NCOLS(NCOLS), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_drain (
        .clk       (Clk),
        .wr_en     (1'b0),
        .wr_row    (ROW0),
        .wr_data   ('0),
        .load_en   (load_drain),
        .load_data (cap_frame),
        .rd_idx    (idx),
        .rd_data   (pix_word),
        .frame     (drain_frame)
    );

`ifdef READOUT_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(2 * NCOLS);
    logic [DATA_W-1:0] csum;

    always_comb begin
        csum = '0;
        for (int w = 0; w < 2 * NCOLS; w++) begin
            csum = csum + drain_frame[w*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        Out_valid = (state == ST_DRAIN);
        Out_last  = Out_valid & (idx == LAST_IDX);
        Out_data  = '0;
        if (Out_valid) begin
            Out_data = (idx == CSUM_IDX) ? csum : pix_word;
        end
    end
`else
    always_comb begin
        Out_valid = (state == ST_DRAIN);
        Out_last  = Out_valid & (idx == LAST_IDX);
        Out_data  = Out_valid ? pix_word : '0;
    end
`endif

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench: table of frames with hand-computed words, plus queue/overrun, erase, sequence-error and reset cases.
module tb_pixel_readout_buffer;

    logic        Clk = 1'b0;
    logic        Reset, NRE_1, NRE_2, ADC, Erase, Out_ready;
    logic [15:0] Pix_data;
    logic [7:0]  Out_data;
    logic        Out_valid, Out_last, Overrun, Seq_err;

    int checks = 0;
    int errors = 0;

`ifdef READOUT_CHECKSUM_EN
    localparam int LEN = 5;
`else
    localparam int LEN = 4;
`endif

    typedef struct packed {
        logic [15:0]     row0;
        logic [15:0]     row1;
        logic [3:0][7:0] words;
        logic [7:0]      csum;
        logic            toggle;
    } vec_t;

    vec_t tbl [4];

    always #5 Clk = ~Clk;

    pixel_readout_buffer #(.NCOLS(2), .DATA_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .NRE_1     (NRE_1),
        .NRE_2     (NRE_2),
        .ADC       (ADC),
        .Erase     (Erase),
        .Pix_data  (Pix_data),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
        .Out_valid (Out_valid),
        .Out_last  (Out_last),
        .Overrun   (Overrun),
        .Seq_err   (Seq_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic capture_row(input logic r, input logic [15:0] d, input logic er);
        @(negedge Clk);
        NRE_1 = r; NRE_2 = ~r; Pix_data = d; ADC = 1'b1; Erase = er;
        @(negedge Clk);
        ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1; Erase = 1'b0;
    endtask

    task automatic erase_pulse();
        @(negedge Clk);
        Erase = 1'b1;
        @(negedge Clk);
        Erase = 1'b0;
    endtask

    task automatic expect_quiet(input int n, input string name);
        repeat (n) begin
            @(negedge Clk);
            check(name, Out_valid, 1'b0);
        end
    endtask

    task automatic collect(input logic [4:0][7:0] w, input bit toggle, input bit immediate);
        int n, cyc;
        bit stalled;
        logic [7:0] held;
        n = 0; cyc = 0; stalled = 0; held = '0;
        while (n < LEN && cyc < 40) begin
            @(negedge Clk);
            Out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (immediate && cyc == 0) check("first_valid", Out_valid, 1'b1);
            if (Out_valid) begin
                if (stalled) check("stall_hold", Out_data, held);
                if (Out_ready) begin
                    check("word", Out_data, w[n]);
                    check("last", Out_last, (n == LEN - 1));
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = Out_data;
                end
            end
            cyc++;
        end
        if (n != LEN) check("frame_timeout", n, LEN);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{row0: 16'h2211, row1: 16'h4433, words: {8'h44, 8'h33, 8'h22, 8'h11}, csum: 8'hAA, toggle: 1'b0};
        tbl[1] = '{row0: 16'h2211, row1: 16'h4433, words: {8'h44, 8'h33, 8'h22, 8'h11}, csum: 8'hAA, toggle: 1'b1};
        tbl[2] = '{row0: 16'hFF00, row1: 16'h807F, words: {8'h80, 8'h7F, 8'hFF, 8'h00}, csum: 8'hFE, toggle: 1'b0};
        tbl[3] = '{row0: 16'h4080, row1: 16'h0A20, words: {8'h0A, 8'h20, 8'h40, 8'h80}, csum: 8'hEA, toggle: 1'b1};

        Reset = 1'b1; NRE_1 = 1'b1; NRE_2 = 1'b1; ADC = 1'b0; Erase = 1'b0;
        Out_ready = 1'b0; Pix_data = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        check("rst_valid", Out_valid, 1'b0);
        check("rst_data", Out_data, 8'h00);
        check("rst_last", Out_last, 1'b0);
        check("rst_overrun", Overrun, 1'b0);
        check("rst_seq_err", Seq_err, 1'b0);

        // Frame table: continuous and stalled readout.
        for (int i = 0; i < 4; i++) begin
            capture_row(1'b0, tbl[i].row0, 1'b0);
            capture_row(1'b1, tbl[i].row1, 1'b0);
            collect({tbl[i].csum, tbl[i].words}, tbl[i].toggle, 1'b1);
            expect_quiet(2, "no_extra_word");
        end
        check("table_overrun", Overrun, 1'b0);

        // Stalled consumer: second frame queues, third is dropped.
        Out_ready = 1'b0;
        capture_row(1'b0, tbl[0].row0, 1'b0);
        capture_row(1'b1, tbl[0].row1, 1'b0);
        capture_row(1'b0, tbl[2].row0, 1'b0);
        capture_row(1'b1, tbl[2].row1, 1'b0);
        repeat (2) @(negedge Clk);
        check("queued_no_overrun", Overrun, 1'b0);
        capture_row(1'b0, tbl[3].row0, 1'b0);
        capture_row(1'b1, tbl[3].row1, 1'b0);
        repeat (2) @(negedge Clk);
        check("drop_overrun", Overrun, 1'b1);
        check("stalled_word0", Out_data, 8'h11);
        collect({tbl[0].csum, tbl[0].words}, 1'b0, 1'b1);
        collect({tbl[2].csum, tbl[2].words}, 1'b0, 1'b1);
        expect_quiet(3, "after_queue");
        check("overrun_sticky", Overrun, 1'b1);
        do_reset();
        check("overrun_cleared", Overrun, 1'b0);

        // Erase wins over a same-cycle ADC edge, then erase between rows.
        capture_row(1'b0, 16'h5555, 1'b0);
        capture_row(1'b1, 16'h6666, 1'b1);
        expect_quiet(3, "erase_prio");
        capture_row(1'b0, 16'h7777, 1'b0);
        erase_pulse();
        capture_row(1'b1, 16'h8888, 1'b0);
        expect_quiet(3, "erase_partial");
        check("erase_no_seq_err", Seq_err, 1'b0);
        erase_pulse();
        capture_row(1'b0, tbl[2].row0, 1'b0);
        capture_row(1'b1, tbl[2].row1, 1'b0);
        collect({tbl[2].csum, tbl[2].words}, 1'b0, 1'b1);
        expect_quiet(2, "erase_after");

        // Illegal NRE combination: flag set, nothing captured.
        @(negedge Clk);
        NRE_1 = 1'b0; NRE_2 = 1'b0; Pix_data = 16'hDEAD; ADC = 1'b1;
        @(negedge Clk);
        ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1;
        check("seq_err_set", Seq_err, 1'b1);
        capture_row(1'b1, 16'hBEEF, 1'b0);
        expect_quiet(3, "seq_err_no_capture");
        check("seq_err_sticky", Seq_err, 1'b1);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("seq_err_reset", Seq_err, 1'b0);
        check("reset_valid", Out_valid, 1'b0);
        check("reset_data", Out_data, 8'h00);
        check("reset_last", Out_last, 1'b0);

        // Reset mid-drain discards the frame.
        Out_ready = 1'b0;
        capture_row(1'b0, tbl[3].row0, 1'b0);
        capture_row(1'b1, tbl[3].row1, 1'b0);
        @(negedge Clk);
        check("middrain_valid", Out_valid, 1'b1);
        check("middrain_word0", Out_data, 8'h80);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("middrain_reset", Out_valid, 1'b0);
        Out_ready = 1'b1;
        expect_quiet(3, "middrain_gone");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
